ccip_mem_responder: RTL and testbench
=====================================

# ccip_mem_responder

CCI-P responder that sits at the host end of the request channels: it accepts c0 read requests and c1 write requests, backs them with a local 2^ADDR_WIDTH x 512-bit line memory, and returns c0 read responses and c1 write acknowledgements with mdata echoed unchanged. The block stands in for host memory behind the instance multiplexer. Because all 16 mdata bits are preserved, the instance tag in mdata[15:14] routes responses back to the issuing instance. A stall input and queue-based almost-full flow control exercise requester back-pressure paths.

## Interface
Parameters:
- ADDR_WIDTH, 10: line-index bits; memory depth 2^ADDR_WIDTH lines.
- LOG2_DEPTH, 6: log2 of the depth of each request queue.
- ALMFULL_SLACK, 16: almost-full asserts when occupancy >= 2^LOG2_DEPTH - ALMFULL_SLACK.
- RSP_DELAY, 0: extra response pipeline stages (0..8) applied to both channels.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- c0_req_valid  in  1  read request strobe.
- c0_req_addr  in  42  cache-line address.
- c0_req_mdata  in  16  read tag.
- c1_req_valid  in  1  write request strobe.
- c1_req_addr  in  42  cache-line address.
- c1_req_mdata  in  16  write tag.
- c1_req_data  in  512  write line.
- stall  in  1  when high, no queue is popped.
- c0TxAlmFull  out  1  read queue almost full.
- c1TxAlmFull  out  1  write queue almost full.
- c0_rsp_valid  out  1  read response strobe.
- c0_rsp_mdata  out  16  echoed read tag.
- c0_rsp_data  out  512  read line.
- c1_rsp_valid  out  1  write ack strobe.
- c1_rsp_mdata  out  16  echoed write tag.
- overflow  out  1  sticky: a request arrived while its queue was full.

## Operation
- Two independent FIFOs hold requests:
  - read queue: {addr index, mdata};
  - write queue: {addr index, mdata, data}.
- Each FIFO keeps an occupancy counter of LOG2_DEPTH+1 bits. Push and pop in the same cycle leave the count unchanged.
- Memory index is c*_req_addr[ADDR_WIDTH-1:0]. Upper address bits are ignored, so addresses wrap around the memory.
- A request whose queue is full (occupancy == 2^LOG2_DEPTH) is dropped and sets overflow. overflow is cleared only by reset.
- While stall is low and a queue is non-empty, its head is popped. Each channel pops at most one entry per cycle, and the two channels pop independently.
- Write pop: the data is committed to memory in the pop cycle.
- Read pop: the memory is read in the pop cycle.
  - If a write to the same index is committed in that same cycle, the read returns the new data (write-first bypass).
- Responses carry no back-pressure; every popped request produces exactly one response.
- Responses on each channel are returned in request order.
- Memory contents are not reset. A read of a never-written line returns undefined data, and the bench must not check it.

## Timing
- Every output is 0 during reset and on the first cycle after reset, including c0_rsp_data (registered, cleared on reset).
- Reset mid-operation:
  - queues are emptied;
  - in-flight responses are discarded and never appear;
  - memory contents are retained.
- Read latency with an empty queue and stall low:
  - request sampled in cycle T; head popped in T+1;
  - memory data available in T+2;
  - c0_rsp_valid high in T+3+RSP_DELAY.
- Write latency with an empty queue and stall low: request sampled in T, popped and committed in T+1, c1_rsp_valid high in T+2+RSP_DELAY.
- With stall low the sustained rate is 1 response per cycle per channel. Queued requests add one cycle of latency each.
- stall asserted in cycle S: no pop occurs in S. Pops already made still complete with their normal latency.
- c*TxAlmFull is combinational from occupancy, so it changes in the cycle after the push or pop that moves the count across the threshold.
- Requests remain accepted while almost-full is asserted, until the queue is full.
- The overflow flag sets in the cycle after the dropped request.

## Test plan
- Write then read, stall low, RSP_DELAY=0:
  - stimulus: write addr 0x5, data 0xA5..A5, mdata 0x4001 at T0; read addr 0x5, mdata 0x8002 at T0+4.
  - required: c1_rsp_valid at T0+2 with mdata 0x4001; c0_rsp_valid at T0+7 with mdata 0x8002 and data 0xA5..A5.
- Same-cycle bypass: stall high; queue write idx 3 = 0x11.., then read idx 3; release stall.
  - required: the read returns 0x11.. rather than the old contents.
- Almost-full and overflow, LOG2_DEPTH=6, ALMFULL_SLACK=16, stall high, push 65 reads:
  - c0TxAlmFull rises after the 48th push;
  - the 65th push is dropped and overflow=1;
  - releasing stall yields exactly 64 responses with mdata in order.
- Wrap-around, ADDR_WIDTH=10: write addr 0x405 with data D, then read addr 0x005 -> data D.
- Back-to-back streams: 100 reads with mdata 0..99 on consecutive cycles.
  - required: 100 consecutive c0_rsp_valid cycles, mdata 0..99 in order, no gaps.
- Reset mid-flight: reset for 2 cycles while 10 reads are queued.
  - required: no responses afterwards, all outputs 0, overflow=0, memory data retained on later reads.

Source files
------------

// File: rtl/ccip_mem_responder_if.sv
// Request/response bundle between a CCI-P requester and the memory responder.
// The requester drives requests and stall; the responder drives everything else.
interface ccip_mem_responder_if;
  logic         c0_req_valid;
  logic [41:0]  c0_req_addr;
  logic [15:0]  c0_req_mdata;
  logic         c1_req_valid;
  logic [41:0]  c1_req_addr;
  logic [15:0]  c1_req_mdata;
  logic [511:0] c1_req_data;
  logic         stall;
  logic         c0TxAlmFull;
  logic         c1TxAlmFull;
  logic         c0_rsp_valid;
  logic [15:0]  c0_rsp_mdata;
  logic [511:0] c0_rsp_data;
  logic         c1_rsp_valid;
  logic [15:0]  c1_rsp_mdata;
  logic         overflow;

  modport master (
    output c0_req_valid, c0_req_addr, c0_req_mdata,
    output c1_req_valid, c1_req_addr, c1_req_mdata, c1_req_data,
    output stall,
    input  c0TxAlmFull, c1TxAlmFull,
    input  c0_rsp_valid, c0_rsp_mdata, c0_rsp_data,
    input  c1_rsp_valid, c1_rsp_mdata,
    input  overflow
  );

  modport slave (
    input  c0_req_valid, c0_req_addr, c0_req_mdata,
    input  c1_req_valid, c1_req_addr, c1_req_mdata, c1_req_data,
    input  stall,
    output c0TxAlmFull, c1TxAlmFull,
    output c0_rsp_valid, c0_rsp_mdata, c0_rsp_data,
    output c1_rsp_valid, c1_rsp_mdata,
    output overflow
  );
endinterface

// File: rtl/ccip_mem_responder.sv
// CCI-P host-memory stand-in: queued c0 reads and c1 writes against a local
// line memory, with in-order responses echoing mdata and almost-full back-pressure.

module ccip_req_fifo #(
  parameter int WIDTH      = 26,
  parameter int LOG2_DEPTH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head,
  output logic [LOG2_DEPTH:0]   count,
  output logic                  empty,
  output logic                  dropped
);
  localparam int DEPTH = 2 ** LOG2_DEPTH;
  localparam logic [LOG2_DEPTH:0] DEPTH_C = (LOG2_DEPTH + 1)'(DEPTH);

  logic [WIDTH-1:0]      storage [DEPTH];
  logic [LOG2_DEPTH-1:0] wr_ptr;
  logic [LOG2_DEPTH-1:0] rd_ptr;
  logic                  full;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dropped = push && full;
  assign head    = storage[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) storage[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + LOG2_DEPTH'(1);
      if (do_pop)  rd_ptr <= rd_ptr + LOG2_DEPTH'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (LOG2_DEPTH + 1)'(1);
        2'b01:   count <= count - (LOG2_DEPTH + 1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module ccip_mem_responder #(
  parameter int ADDR_WIDTH    = 10,
  parameter int LOG2_DEPTH    = 6,
  parameter int ALMFULL_SLACK = 16,
  parameter int RSP_DELAY     = 0
) (
  input logic                 clk,
  input logic                 reset,
  ccip_mem_responder_if.slave bus
);
  localparam int RD_W = ADDR_WIDTH + 16;
  localparam int WR_W = ADDR_WIDTH + 16 + 512;
  localparam logic [LOG2_DEPTH:0] THRESH_C =
    (LOG2_DEPTH + 1)'((2 ** LOG2_DEPTH) - ALMFULL_SLACK);

  logic [RD_W-1:0]       rd_head;
  logic [WR_W-1:0]       wr_head;
  logic [LOG2_DEPTH:0]   rd_count;
  logic [LOG2_DEPTH:0]   wr_count;
  logic                  rd_empty;
  logic                  wr_empty;
  logic                  rd_drop;
  logic                  wr_drop;
  logic                  rd_pop;
  logic                  wr_pop;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic [15:0]           rd_mdata;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic [15:0]           wr_mdata;
  logic [511:0]          wr_data;

  logic [511:0]          line_mem [2 ** ADDR_WIDTH];

  logic                  rd_s_valid;
  logic [15:0]           rd_s_mdata;
  logic [511:0]          rd_s_data;

  logic                  c0_v_pipe [0:RSP_DELAY];
  logic [15:0]           c0_m_pipe [0:RSP_DELAY];
  logic [511:0]          c0_d_pipe [0:RSP_DELAY];
  logic                  c1_v_pipe [0:RSP_DELAY];
  logic [15:0]           c1_m_pipe [0:RSP_DELAY];

  logic                  overflow_q;
  logic                  unused_addr_bits;

  // Upper address bits are deliberately dropped so accesses wrap the memory.
  assign unused_addr_bits = ^{bus.c0_req_addr[41:ADDR_WIDTH], bus.c1_req_addr[41:ADDR_WIDTH]};

  ccip_req_fifo #(.WIDTH(RD_W), .LOG2_DEPTH(LOG2_DEPTH)) rd_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (bus.c0_req_valid),
    .push_data ({bus.c0_req_addr[ADDR_WIDTH-1:0], bus.c0_req_mdata}),
    .pop       (rd_pop),
    .head      (rd_head),
    .count     (rd_count),
    .empty     (rd_empty),
    .dropped   (rd_drop)
  );

  ccip_req_fifo #(.WIDTH(WR_W), .LOG2_DEPTH(LOG2_DEPTH)) wr_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (bus.c1_req_valid),
    .push_data ({bus.c1_req_addr[ADDR_WIDTH-1:0], bus.c1_req_mdata, bus.c1_req_data}),
    .pop       (wr_pop),
    .head      (wr_head),
    .count     (wr_count),
    .empty     (wr_empty),
    .dropped   (wr_drop)
  );

  assign rd_pop   = !bus.stall && !rd_empty;
  assign wr_pop   = !bus.stall && !wr_empty;
  assign rd_idx   = rd_head[RD_W-1:16];
  assign rd_mdata = rd_head[15:0];
  assign wr_idx   = wr_head[WR_W-1:528];
  assign wr_mdata = wr_head[527:512];
  assign wr_data  = wr_head[511:0];

  assign bus.c0TxAlmFull = !reset && (rd_count >= THRESH_C);
  assign bus.c1TxAlmFull = !reset && (wr_count >= THRESH_C);

  always_ff @(posedge clk) begin
    if (wr_pop) line_mem[wr_idx] <= wr_data;
  end

  // Write-first: a read popped alongside a write to the same line sees the new data.
  always_ff @(posedge clk) begin
    if (rd_pop) rd_s_data <= (wr_pop && (wr_idx == rd_idx)) ? wr_data : line_mem[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_s_valid <= 1'b0;
      rd_s_mdata <= '0;
    end else begin
      rd_s_valid <= rd_pop;
      rd_s_mdata <= rd_pop ? rd_mdata : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i <= RSP_DELAY; i++) begin
        c0_v_pipe[i] <= 1'b0;
        c0_m_pipe[i] <= '0;
        c0_d_pipe[i] <= '0;
        c1_v_pipe[i] <= 1'b0;
        c1_m_pipe[i] <= '0;
      end
    end else begin
      c0_v_pipe[0] <= rd_s_valid;
      c0_m_pipe[0] <= rd_s_valid ? rd_s_mdata : '0;
      c0_d_pipe[0] <= rd_s_valid ? rd_s_data : '0;
      c1_v_pipe[0] <= wr_pop;
      c1_m_pipe[0] <= wr_pop ? wr_mdata : '0;
      for (int i = 1; i <= RSP_DELAY; i++) begin
        c0_v_pipe[i] <= c0_v_pipe[i-1];
        c0_m_pipe[i] <= c0_m_pipe[i-1];
        c0_d_pipe[i] <= c0_d_pipe[i-1];
        c1_v_pipe[i] <= c1_v_pipe[i-1];
        c1_m_pipe[i] <= c1_m_pipe[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                   overflow_q <= 1'b0;
    else if (rd_drop || wr_drop) overflow_q <= 1'b1;
  end

  assign bus.c0_rsp_valid = c0_v_pipe[RSP_DELAY];
  assign bus.c0_rsp_mdata = c0_m_pipe[RSP_DELAY];
  assign bus.c0_rsp_data  = c0_d_pipe[RSP_DELAY];
  assign bus.c1_rsp_valid = c1_v_pipe[RSP_DELAY];
  assign bus.c1_rsp_mdata = c1_m_pipe[RSP_DELAY];
  assign bus.overflow     = overflow_q;
endmodule

// File: tb/tb_ccip_mem_responder.sv
// Scoreboard bench for ccip_mem_responder: expectations are queued as requests
// are driven and matched in order against responses seen on the falling edge.
module tb_ccip_mem_responder;
  localparam int ADDR_WIDTH    = 10;
  localparam int LOG2_DEPTH    = 6;
  localparam int ALMFULL_SLACK = 16;
  localparam int RSP_DELAY     = 0;

  typedef struct {
    logic [15:0]  mdata;
    logic [511:0] data;
    bit           chk_data;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ccip_mem_responder_if bus ();

  ccip_mem_responder #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .LOG2_DEPTH    (LOG2_DEPTH),
    .ALMFULL_SLACK (ALMFULL_SLACK),
    .RSP_DELAY     (RSP_DELAY)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t         c0_exp [$];
  exp_t         c1_exp [$];
  exp_t         m0;
  exp_t         m1;
  logic [511:0] model_mem [int];
  int           c0_cycles [$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           c0_rsp_cnt = 0;
  int           c1_rsp_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [511:0] actual, input logic [511:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Responses are matched in order against the head of each channel's queue.
  always @(negedge clk) begin
    if (bus.c0_rsp_valid) begin
      c0_rsp_cnt++;
      c0_cycles.push_back(cyc);
      if (c0_exp.size() == 0) checkOutput("c0_unexpected_rsp", 1, 0);
      else begin
        m0 = c0_exp.pop_front();
        checkOutput("c0_mdata", bus.c0_rsp_mdata, m0.mdata);
        if (m0.chk_data) checkOutput("c0_data", bus.c0_rsp_data, m0.data);
        if (m0.cyc >= 0) checkOutput("c0_latency", cyc, m0.cyc);
      end
    end
    if (bus.c1_rsp_valid) begin
      c1_rsp_cnt++;
      if (c1_exp.size() == 0) checkOutput("c1_unexpected_rsp", 1, 0);
      else begin
        m1 = c1_exp.pop_front();
        checkOutput("c1_mdata", bus.c1_rsp_mdata, m1.mdata);
        if (m1.cyc >= 0) checkOutput("c1_latency", cyc, m1.cyc);
      end
    end
  end

  task automatic applyStimulus(input bit rv, input logic [41:0] ra, input logic [15:0] rm,
                               input bit wv, input logic [41:0] wa, input logic [15:0] wm,
                               input logic [511:0] wd);
    bus.c0_req_valid = rv;
    bus.c0_req_addr  = ra;
    bus.c0_req_mdata = rm;
    bus.c1_req_valid = wv;
    bus.c1_req_addr  = wa;
    bus.c1_req_mdata = wm;
    bus.c1_req_data  = wd;
    @(posedge clk);
    #1;
    bus.c0_req_valid = 1'b0;
    bus.c1_req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, '0, '0, 0, '0, '0, '0);
  endtask

  task automatic exp_write(input logic [41:0] addr, input logic [15:0] mdata,
                           input logic [511:0] data, input int lat);
    exp_t e;
    int   idx;
    idx        = int'(addr[ADDR_WIDTH-1:0]);
    model_mem[idx] = data;
    e.mdata    = mdata;
    e.data     = '0;
    e.chk_data = 1'b0;
    e.cyc      = (lat < 0) ? -1 : cyc + lat;
    c1_exp.push_back(e);
  endtask

  task automatic exp_read(input logic [41:0] addr, input logic [15:0] mdata, input int lat);
    exp_t e;
    int   idx;
    idx        = int'(addr[ADDR_WIDTH-1:0]);
    e.mdata    = mdata;
    e.chk_data = model_mem.exists(idx);
    e.data     = '0;
    if (e.chk_data) e.data = model_mem[idx];
    e.cyc      = (lat < 0) ? -1 : cyc + lat;
    c0_exp.push_back(e);
  endtask

  task automatic write_line(input logic [41:0] addr, input logic [15:0] mdata,
                            input logic [511:0] data, input int lat);
    exp_write(addr, mdata, data, lat);
    applyStimulus(0, '0, '0, 1, addr, mdata, data);
  endtask

  task automatic read_line(input logic [41:0] addr, input logic [15:0] mdata, input int lat);
    exp_read(addr, mdata, lat);
    applyStimulus(1, addr, mdata, 0, '0, '0, '0);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((c0_exp.size() != 0 || c1_exp.size() != 0) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    repeat (8) @(posedge clk);
    #1;
    checkOutput("drain_outstanding", c0_exp.size() + c1_exp.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [511:0] pat_a5, pat_11, pat_22, pat_d, pat_x;
    int base, base1;
    pat_a5 = {64{8'hA5}};
    pat_11 = {64{8'h11}};
    pat_22 = {64{8'h22}};
    pat_d  = {16{32'hDEADBEEF}};
    pat_x  = {16{32'h0BADF00D}};

    reset = 1'b1;
    bus.stall = 1'b0;
    bus.c0_req_valid = 1'b0; bus.c0_req_addr = '0; bus.c0_req_mdata = '0;
    bus.c1_req_valid = 1'b0; bus.c1_req_addr = '0; bus.c1_req_mdata = '0;
    bus.c1_req_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_c0_valid", bus.c0_rsp_valid, 0);
    checkOutput("rst_c1_valid", bus.c1_rsp_valid, 0);
    checkOutput("rst_overflow", bus.overflow, 0);
    checkOutput("rst_almfull", {bus.c0TxAlmFull, bus.c1TxAlmFull}, 0);
    reset = 1'b0;
    checkOutput("post_rst_c0_data", bus.c0_rsp_data, 0);
    checkOutput("post_rst_mdata", {bus.c0_rsp_mdata, bus.c1_rsp_mdata}, 0);

    $display("[TB] write then read with exact latency");
    write_line(42'h5, 16'h4001, pat_a5, 2);
    idle(3);
    read_line(42'h5, 16'h8002, 3);
    wait_drain();

    $display("[TB] address wrap-around");
    write_line(42'h405, 16'h4003, pat_d, -1);
    wait_drain();
    read_line(42'h005, 16'h8004, -1);
    wait_drain();

    $display("[TB] same-cycle write/read bypass");
    write_line(42'h3, 16'h4005, pat_22, -1);
    wait_drain();
    bus.stall = 1'b1;
    exp_write(42'h3, 16'h4006, pat_11, -1);
    exp_read(42'h3, 16'h8006, -1);
    applyStimulus(1, 42'h3, 16'h8006, 1, 42'h3, 16'h4006, pat_11);
    idle(3);
    checkOutput("stall_holds_c0", c0_exp.size(), 1);
    bus.stall = 1'b0;
    wait_drain();

    $display("[TB] back-to-back read stream");
    base = c0_cycles.size();
    for (int i = 0; i < 100; i++) read_line(42'h5, 16'(i), 3);
    wait_drain();
    checkOutput("stream_count", c0_cycles.size() - base, 100);
    checkOutput("stream_span", c0_cycles[base+99] - c0_cycles[base], 99);

    $display("[TB] almost-full and overflow");
    bus.stall = 1'b1;
    base = c0_rsp_cnt;
    for (int i = 1; i <= 65; i++) begin
      if (i <= 64) read_line(42'h5, 16'h1000 + 16'(i), -1);
      else applyStimulus(1, 42'h5, 16'h1000 + 16'(i), 0, '0, '0, '0);
      if (i == 47) checkOutput("almfull_47", bus.c0TxAlmFull, 0);
      if (i == 48) checkOutput("almfull_48", bus.c0TxAlmFull, 1);
      if (i == 48) checkOutput("c1_almfull_idle", bus.c1TxAlmFull, 0);
      if (i == 64) checkOutput("overflow_64", bus.overflow, 0);
      if (i == 65) checkOutput("overflow_65", bus.overflow, 1);
    end
    bus.stall = 1'b0;
    wait_drain();
    checkOutput("almfull_drained", bus.c0TxAlmFull, 0);
    checkOutput("full_rsp_count", c0_rsp_cnt - base, 64);

    $display("[TB] reset mid-flight");
    write_line(42'h7, 16'h4007, pat_x, -1);
    wait_drain();
    bus.stall = 1'b1;
    for (int i = 0; i < 10; i++) applyStimulus(1, 42'h7, 16'h2000 + 16'(i), 0, '0, '0, '0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst_overflow", bus.overflow, 0);
    checkOutput("midrst_almfull", bus.c0TxAlmFull, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("afterrst_valids", {bus.c0_rsp_valid, bus.c1_rsp_valid}, 0);
    checkOutput("afterrst_c0_data", bus.c0_rsp_data, 0);
    checkOutput("afterrst_overflow", bus.overflow, 0);
    bus.stall = 1'b0;
    base  = c0_rsp_cnt;
    base1 = c1_rsp_cnt;
    idle(20);
    checkOutput("afterrst_no_c0_rsp", c0_rsp_cnt - base, 0);
    checkOutput("afterrst_no_c1_rsp", c1_rsp_cnt - base1, 0);
    read_line(42'h7, 16'h8008, 3);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
